// File: rtl/tsc_pkg.sv
// Shared types for the TriggerSurroundCache readout sequencer.
// Holds the state encoding, the header length and the header byte selector.
package tsc_pkg;

    localparam int TSC_HDR_BYTES = 4;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        WAIT_TRIG,
        WAIT_CD,
        HDR,
        REQ,
        WAIT_RDY,
        PUSH,
        DONE
    } tsc_state_e;

    // Header goes out most significant byte first.
    function automatic logic [7:0] hdrByte(input logic [31:0] stamp, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = stamp[31:24];
            2'd1:    b = stamp[23:16];
            2'd2:    b = stamp[15:8];
            default: b = stamp[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tsc_readout_ctrl_if.sv
// Host control, TSC handshake and serial-buffer signals of the readout sequencer.
// The master side is the sequencer; the slave side is its environment.
interface tsc_readout_ctrl_if;

    logic        enable;
    logic        single;
    logic        tsc_start;
    logic        tsc_trd;
    logic        tsc_cd;
    logic [31:0] tsc_trigtm;
    logic        tsc_req;
    logic        tsc_rdy;
    logic [7:0]  tsc_dat;
    logic        tsc_sd;
    logic        sbf;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        short_frame;
    logic        timeout_err;

    modport master (
        input  enable, single, tsc_trd, tsc_cd, tsc_trigtm, tsc_rdy, tsc_dat, tsc_sd, sbf,
        output tsc_start, tsc_req, out_data, out_valid, busy, frame_cnt, short_frame, timeout_err
    );

    modport slave (
        output enable, single, tsc_trd, tsc_cd, tsc_trigtm, tsc_rdy, tsc_dat, tsc_sd, sbf,
        input  tsc_start, tsc_req, out_data, out_valid, busy, frame_cnt, short_frame, timeout_err
    );

endinterface

// File: rtl/tsc_timeout.sv
// Loadable down-counter guarding the wait for tsc_rdy.
// Loading LIMIT-1 makes expired_o rise on the LIMIT-th cycle after the load cycle.
module tsc_timeout #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = W'(LIMIT - 1);
        end else if (en_i && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/tsc_readout_ctrl.sv
// Arms the TriggerSurroundCache, waits for trigger and cache-done, then streams a
// 4-byte timestamp header followed by the cached samples to the serial buffer.
module tsc_readout_ctrl
    import tsc_pkg::*;
#(
    parameter int CACHE_DEPTH = 32,
    parameter int RDY_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    tsc_readout_ctrl_if.master  ctrl
);

    localparam int BW = $clog2(CACHE_DEPTH + 1);
    localparam logic [BW-1:0] DEPTH_C = BW'(CACHE_DEPTH);

    tsc_state_e    state_q, state_d;
    logic [31:0]   stamp_q, stamp_d;
    logic [1:0]    hdrIdx_q, hdrIdx_d;
    logic [BW-1:0] byteCnt_q, byteCnt_d;
    logic [7:0]    sample_q, sample_d;
    logic [15:0]   frameCnt_q, frameCnt_d;
    logic          shortFrame_q, shortFrame_d;
    logic          timeoutErr_q, timeoutErr_d;

    logic          tmrLoad;
    logic          tmrEn;
    logic          tmrExpired;
    logic [BW-1:0] cntInc;
    logic [7:0]    outData;

    tsc_timeout #(
        .LIMIT (RDY_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmrLoad),
        .en_i      (tmrEn),
        .expired_o (tmrExpired)
    );

    assign cntInc = byteCnt_q + BW'(1);

    always_comb begin
        state_d      = state_q;
        stamp_d      = stamp_q;
        hdrIdx_d     = hdrIdx_q;
        byteCnt_d    = byteCnt_q;
        sample_d     = sample_q;
        frameCnt_d   = frameCnt_q;
        shortFrame_d = shortFrame_q;
        timeoutErr_d = timeoutErr_q;
        tmrLoad      = 1'b0;
        tmrEn        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl.enable) begin
                    shortFrame_d = 1'b0;
                    timeoutErr_d = 1'b0;
                    state_d      = ARM;
                end
            end
            ARM: state_d = WAIT_TRIG;
            // A trigger in the same cycle as an enable drop still wins.
            WAIT_TRIG: begin
                if (ctrl.tsc_trd) begin
                    state_d = WAIT_CD;
                end else if (!ctrl.enable) begin
                    state_d = IDLE;
                end
            end
            WAIT_CD: begin
                if (ctrl.tsc_cd) begin
                    stamp_d   = ctrl.tsc_trigtm;
                    hdrIdx_d  = 2'd0;
                    byteCnt_d = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (!ctrl.sbf) begin
                    hdrIdx_d = hdrIdx_q + 2'd1;
                    if (hdrIdx_q == 2'(TSC_HDR_BYTES - 1)) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                tmrLoad = 1'b1;
                state_d = WAIT_RDY;
            end
            // Data arriving on the expiry cycle is still taken.
            WAIT_RDY: begin
                tmrEn = 1'b1;
                if (ctrl.tsc_rdy) begin
                    sample_d = ctrl.tsc_dat;
                    state_d  = PUSH;
                end else if (tmrExpired) begin
                    timeoutErr_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            PUSH: begin
                if (!ctrl.sbf) begin
                    byteCnt_d = cntInc;
                    if (cntInc == DEPTH_C) begin
                        state_d = DONE;
                    end else if (ctrl.tsc_sd) begin
                        shortFrame_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                frameCnt_d = frameCnt_q + 16'd1;
                state_d    = (ctrl.enable && !ctrl.single) ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            stamp_q      <= '0;
            hdrIdx_q     <= '0;
            byteCnt_q    <= '0;
            sample_q     <= '0;
            frameCnt_q   <= '0;
            shortFrame_q <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stamp_q      <= stamp_d;
            hdrIdx_q     <= hdrIdx_d;
            byteCnt_q    <= byteCnt_d;
            sample_q     <= sample_d;
            frameCnt_q   <= frameCnt_d;
            shortFrame_q <= shortFrame_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    always_comb begin
        outData = 8'h00;
        if (state_q == HDR) begin
            outData = hdrByte(stamp_q, hdrIdx_q);
        end else if (state_q == PUSH) begin
            outData = sample_q;
        end
    end

    assign ctrl.tsc_start   = (state_q == ARM);
    assign ctrl.tsc_req     = (state_q == REQ);
    assign ctrl.out_valid   = (state_q == HDR) || (state_q == PUSH);
    assign ctrl.out_data    = outData;
    assign ctrl.busy        = (state_q != IDLE);
    assign ctrl.frame_cnt   = frameCnt_q;
    assign ctrl.short_frame = shortFrame_q;
    assign ctrl.timeout_err = timeoutErr_q;

endmodule

// File: doc/tsc_readout_ctrl.md
# tsc_readout_ctrl

Sequencer for the TriggerSurroundCache (TSC). It arms the cache with a one-cycle `start` pulse and waits for the trigger and cache-done indications. It then drains the cached samples byte-by-byte over the TSC `req`/`rdy` handshake and forwards them, behind a 4-byte trigger-timestamp header, to the downstream serial buffer. It sits between host control registers and the TSC, and owns all TSC control inputs.

## Interface
Parameters:
- `CACHE_DEPTH`, 32: sample bytes drained per trigger frame (≥1).
- `RDY_TIMEOUT`, 64: max cycles from `tsc_req` to `tsc_rdy` before error (≥2).

Ports:
- `clk`  in  1  single system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; all state and outputs clear immediately.
- `enable`  in  1  host arm request (level).
- `single`  in  1  1 = one frame then idle; 0 = re-arm continuously while `enable`.
- `tsc_start`  out  1  one-cycle arm pulse to TSC.
- `tsc_trd`  in  1  TSC trigger detected.
- `tsc_cd`  in  1  TSC cache done (post-trigger capture complete).
- `tsc_trigtm`  in  32  trigger timestamp, valid while `tsc_cd`=1.
- `tsc_req`  out  1  one-cycle read request for next cached byte.
- `tsc_rdy`  in  1  TSC byte valid on `tsc_dat`.
- `tsc_dat`  in  8  cached sample byte.
- `tsc_sd`  in  1  TSC send done (cache exhausted).
- `sbf`  in  1  downstream serial buffer full; byte accepted when `out_valid`=1 and `sbf`=0.
- `out_data`  out  8  byte to serial buffer.
- `out_valid`  out  1  `out_data` valid.
- `busy`  out  1  high in any state except IDLE.
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0.
- `short_frame`  out  1  sticky: last frame ended early on `tsc_sd`.
- `timeout_err`  out  1  sticky: `tsc_rdy` timeout occurred.

## Operation
- Reset values: all outputs 0, state IDLE, counters 0.
- IDLE: `enable`=1 → ARM; clears `short_frame`, `timeout_err`.
- ARM: `tsc_start`=1 for exactly one cycle → WAIT_TRIG.
- WAIT_TRIG: `tsc_trd`=1 → WAIT_CD; `enable`=0 → IDLE (abort, no frame counted).
- WAIT_CD: `tsc_cd`=1 → latch `tsc_trigtm`, hdr index 0 → HDR. `enable` is ignored once a trigger is seen.
- HDR: present timestamp bytes MSB first (`[31:24]` … `[7:0]`); advance on each accept; after byte 3 accepted → REQ.
- REQ: `tsc_req`=1 one cycle, reset timeout counter → WAIT_RDY.
- WAIT_RDY: `tsc_rdy`=1 → latch `tsc_dat` → PUSH. If the counter reaches `RDY_TIMEOUT` → set `timeout_err`, IDLE (frame not counted).
- PUSH: hold `out_valid` until accepted. After accept: if byte count = `CACHE_DEPTH` → DONE; else if `tsc_sd`=1 → set `short_frame`, DONE; else REQ.
- DONE: `frame_cnt`+1. Then → ARM if `enable`=1 and `single`=0, else IDLE.
- Byte counter width is `$clog2(CACHE_DEPTH+1)`. Timeout counter width is `$clog2(RDY_TIMEOUT+1)`.
- `tsc_rdy` outside WAIT_RDY is ignored. `tsc_trd`/`tsc_cd` outside their wait states are ignored.
- `tsc_rdy` and the timeout occurring in the same cycle: data wins, no error.

## Timing
- `tsc_start` asserts the cycle after ARM is entered from `enable`; IDLE→ARM takes 1 cycle.
- `tsc_cd` at cycle N → first header byte `out_valid` at N+1.
- With `sbf`=0 and `tsc_rdy` returned one cycle after `tsc_req`, each sample byte costs 3 cycles (REQ, WAIT_RDY, PUSH).
- `out_data` is registered and stable while `out_valid`=1 and `sbf`=1; it never changes before acceptance.
- `tsc_req` is never reasserted until the previous byte is accepted downstream. At most one outstanding request.
- Asynchronous `reset` mid-frame: outputs 0 at once. No partial frame resumes after release; the next arm restarts at ARM.

## Structure
- Package `tsc_pkg`: state enum (IDLE, ARM, WAIT_TRIG, WAIT_CD, HDR, REQ, WAIT_RDY, PUSH, DONE) and `TSC_HDR_BYTES`=4.
- One sub-module, `tsc_timeout`: loadable down-counter with an `expired` flag, used in WAIT_RDY.
- Everything else is a single FSM plus datapath registers in `tsc_readout_ctrl`.

## Test plan
- Single frame: `single`=1, `enable`=1, trigtm=0xDEADBEEF, TSC returns bytes 0..31, `sbf`=0 → `out_data` sequence DE AD BE EF 00..1F, `frame_cnt`=1, then IDLE with `busy`=0.
- Backpressure: same run with `sbf` toggled 1/0 every 3 cycles → identical 36-byte stream, no byte dropped or duplicated, `tsc_req` count = 32.
- Early end: `tsc_sd`=1 with byte 10 → 4+10 bytes out, `short_frame`=1, `frame_cnt`+1.
- Timeout: TSC never returns `tsc_rdy` after the 5th `tsc_req` → `timeout_err`=1 at `RDY_TIMEOUT` cycles, IDLE, `frame_cnt` unchanged.
- Continuous: `single`=0, 3 triggers → 3 `tsc_start` pulses plus one more re-arm, `frame_cnt`=3. Drop `enable` in WAIT_TRIG → IDLE within 1 cycle.
- Reset mid-PUSH: assert `reset` → all outputs 0 the same cycle. After release with `enable`=1, first `tsc_start` comes 1 cycle later.
